// File: rtl/ram_mar_unit_pkg.sv
// Shared CPU definitions: default widths, loader state encoding and the
// bit positions of the memory control signals within the control word.
package ram_mar_unit_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2
  } ldr_state_e;

  // Bit positions of the memory-related signals within the control word.
  localparam int CTL_LM = 0;
  localparam int CTL_CE = 1;
  localparam int CTL_WE = 2;
  localparam int CTL_W  = 3;

endpackage : ram_mar_unit_pkg

// File: rtl/ram_mar_unit_prog_loader.sv
// Byte-wide program loader: owns the RAM write port while a program is
// streamed in through a valid/ready handshake.
module ram_mar_unit_prog_loader
  import ram_mar_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              ldr_idle,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ldr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  // NOTE: sequential state uses non-blocking assignments only; the
  // combinational block below computes next values with blocking ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LDR_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    wr_en      = 1'b0;
    prog_ready = 1'b0;
    prog_done  = 1'b0;
    unique case (state)
      LDR_IDLE: begin
        if (prog_mode) begin
          state_nxt = LDR_LOAD;
          ptr_nxt   = '0;
        end
      end
      LDR_LOAD: begin
        prog_ready = 1'b1;
        if (prog_valid) begin
          wr_en   = 1'b1;
          ptr_nxt = ptr + ADDR_W'(1);
        end
        // An abort still commits a byte handed over in the same cycle.
        if (!prog_mode) begin
          state_nxt = LDR_IDLE;
        end else if (prog_valid && (ptr == LAST_ADDR || prog_last)) begin
          state_nxt = LDR_DONE;
        end
      end
      LDR_DONE: begin
        prog_done = 1'b1;
        if (!prog_mode) state_nxt = LDR_IDLE;
      end
      default: state_nxt = LDR_IDLE;
    endcase
  end

  assign ldr_idle = (state == LDR_IDLE);
  assign wr_addr  = ptr;
  assign wr_data  = prog_data;

endmodule : ram_mar_unit_prog_loader

// File: rtl/ram_mar_unit.sv
// Memory address register plus flop-based RAM on the shared CPU bus, with a
// program loader that takes over the RAM while the CPU is held off.
module ram_mar_unit
  import ram_mar_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              lm,
  input  logic              ce,
  input  logic              we,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W-1:0] mar
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CTL_W-1:0]  ctl;
  logic              ldr_idle;
  logic              ldr_wr_en;
  logic [ADDR_W-1:0] ldr_wr_addr;
  logic [DATA_W-1:0] ldr_wr_data;
  logic              cpu_lm;
  logic              cpu_ce;
  logic              cpu_we;

  always_comb begin
    ctl         = '0;
    ctl[CTL_LM] = lm;
    ctl[CTL_CE] = ce;
    ctl[CTL_WE] = we;
  end

  // CPU controls only act while the loader is idle; a read wins over a write.
  assign cpu_lm = ldr_idle & ctl[CTL_LM];
  assign cpu_ce = ldr_idle & ctl[CTL_CE];
  assign cpu_we = ldr_idle & ctl[CTL_WE] & ~ctl[CTL_CE];

  ram_mar_unit_prog_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_prog_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .ldr_idle   (ldr_idle),
    .wr_en      (ldr_wr_en),
    .wr_addr    (ldr_wr_addr),
    .wr_data    (ldr_wr_data)
  );

  // NOTE: the RAM is built from flops and is cleared by reset, so every word
  // sits in the async-reset branch; a macro RAM could not be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (ldr_wr_en) begin
        mem[ldr_wr_addr] <= ldr_wr_data;
      end else if (cpu_we) begin
        mem[mar] <= bus_in;
      end
      if (cpu_lm) mar <= bus_in[ADDR_W-1:0];
    end
  end

  assign bus_oe  = cpu_ce;
  assign bus_out = cpu_ce ? mem[mar] : '0;

endmodule : ram_mar_unit

// File: tb/tb_ram_mar_unit.sv
// Self-checking bench for ram_mar_unit: directed scenarios followed by random
// traffic, all compared against a behavioural memory/loader model.
module tb_ram_mar_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       lm, ce, we;
  logic       prog_mode, prog_valid, prog_last;
  logic [7:0] prog_data;
  logic       prog_ready, prog_done;
  logic [3:0] mar;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode 0 = CPU owns RAM, 1 = loading, 2 = load finished.
  logic [7:0] m_mem [16];
  logic [3:0] m_mar;
  int         m_mode;
  int         m_cnt;

  ram_mar_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .lm         (lm),
    .ce         (ce),
    .we         (we),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .mar        (mar)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_mar  = 4'h0;
    m_mode = 0;
    m_cnt  = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step();
    case (m_mode)
      0: begin
        if (we && !ce) m_mem[m_mar] = bus_in;
        if (lm) m_mar = bus_in[3:0];
        if (prog_mode) begin
          m_mode = 1;
          m_cnt  = 0;
        end
      end
      1: begin
        if (prog_valid) begin
          m_mem[m_cnt] = prog_data;
          m_cnt++;
        end
        if (!prog_mode) m_mode = 0;
        else if (prog_valid && (m_cnt == 16 || prog_last)) m_mode = 2;
      end
      default: if (!prog_mode) m_mode = 0;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    logic       e_oe;
    logic [7:0] e_out;
    #1;
    e_oe  = (m_mode == 0) && ce;
    e_out = e_oe ? m_mem[m_mar] : 8'h00;
    check({tag, ".bus_oe"},     bus_oe,     e_oe);
    check({tag, ".bus_out"},    bus_out,    e_out);
    check({tag, ".mar"},        mar,        m_mar);
    check({tag, ".prog_ready"}, prog_ready, m_mode == 1);
    check({tag, ".prog_done"},  prog_done,  m_mode == 2);
  endtask

  task automatic idle_inputs();
    lm = 0; ce = 0; we = 0; bus_in = 8'h00;
    prog_valid = 0; prog_last = 0; prog_data = 8'h00;
  endtask

  // CPU readback: load MAR, then enable the RAM onto the bus.
  task automatic read_addr(input string tag, input logic [3:0] a, input logic [7:0] exp);
    lm = 1; ce = 0; we = 0; bus_in = {4'h0, a};
    tick();
    lm = 0; ce = 1;
    #1;
    check({tag, ".data"}, bus_out, exp);
    check({tag, ".model"}, bus_out, m_mem[a]);
    ce = 0;
  endtask

  initial begin
    int ready_cnt;
    rst_n = 0; prog_mode = 0;
    idle_inputs();
    model_reset();
    #12 rst_n = 1;
    check_outs("reset");

    // Reset then read at address 5.
    lm = 1; bus_in = 8'h05;
    tick();
    lm = 0; ce = 1;
    #1;
    check("rst_read.mar", mar, 4'h5);
    check("rst_read.oe", bus_oe, 1'b1);
    check("rst_read.out", bus_out, 8'h00);
    ce = 0;

    // CPU write and readback, then concurrent lm+we.
    lm = 1; bus_in = 8'h03; tick();
    lm = 0; we = 1; bus_in = 8'hA5; tick();
    we = 0; ce = 1;
    #1;
    check("wr_rd.out", bus_out, 8'hA5);
    ce = 0;
    lm = 1; we = 1; bus_in = 8'h07; tick();
    lm = 0; we = 0;
    check_outs("lm_we");
    check("lm_we.mar", mar, 4'h7);
    read_addr("lm_we.old", 4'h3, 8'h07);

    // Full 16-byte program load with ce held high.
    prog_mode = 1; ce = 0;
    tick();
    ready_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1; prog_data = 8'h10 + 8'(i); ce = 1;
      check_outs("load");
      check("load.oe", bus_oe, 1'b0);
      if (prog_ready) ready_cnt++;
      tick();
    end
    prog_valid = 0; ce = 0;
    check_outs("load_end");
    check("load.done", prog_done, 1'b1);
    check("load.ready_cycles", ready_cnt, 16);
    prog_mode = 0;
    tick();
    for (int i = 0; i < 16; i++) read_addr("load_rb", 4'(i), 8'h10 + 8'(i));

    // Early termination on prog_last.
    prog_mode = 1; tick();
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1; prog_data = 8'hC0 + 8'(i); prog_last = (i == 2);
      check_outs("early");
      tick();
    end
    prog_valid = 0; prog_last = 0;
    check("early.done", prog_done, 1'b1);
    tick();
    check_outs("early_hold");
    prog_mode = 0; tick();
    check_outs("early_idle");
    for (int i = 0; i < 16; i++)
      read_addr("early_rb", 4'(i), (i < 3) ? 8'hC0 + 8'(i) : 8'h10 + 8'(i));

    // Abort after two bytes.
    prog_mode = 1; tick();
    for (int i = 0; i < 2; i++) begin
      prog_valid = 1; prog_data = 8'hA0 + 8'(i);
      tick();
    end
    prog_valid = 0; prog_mode = 0;
    tick();
    check("abort.ready", prog_ready, 1'b0);
    check("abort.done", prog_done, 1'b0);
    read_addr("abort0", 4'h0, 8'hA0);
    read_addr("abort1", 4'h1, 8'hA1);
    read_addr("abort2", 4'h2, 8'hC2);

    // Restart, then reset in the middle of the stream.
    prog_mode = 1; tick();
    for (int i = 0; i < 3; i++) begin
      prog_valid = 1; prog_data = 8'h55 + 8'(i);
      tick();
    end
    check("mid.ready_before", prog_ready, 1'b1);
    rst_n = 0;
    #1;
    check("mid.ready_async", prog_ready, 1'b0);
    check("mid.done", prog_done, 1'b0);
    check("mid.mar", mar, 4'h0);
    check("mid.oe", bus_oe, 1'b0);
    model_reset();
    prog_mode = 0;
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1;
    check_outs("mid_after");
    for (int i = 0; i < 16; i++) read_addr("mid_rb", 4'(i), 8'h00);

    // Bus contention: ce and we together must not write.
    lm = 1; bus_in = 8'h02; tick();
    lm = 0; we = 1; bus_in = 8'h3C; tick();
    ce = 1; we = 1; bus_in = 8'hFF;
    #1;
    check("cont.out", bus_out, 8'h3C);
    tick();
    ce = 0; we = 0;
    read_addr("cont.keep", 4'h2, 8'h3C);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) prog_mode = ~prog_mode;
      lm         = ($urandom_range(0, 3) == 0);
      ce         = $urandom_range(0, 1);
      we         = $urandom_range(0, 1);
      bus_in     = 8'($urandom);
      prog_valid = $urandom_range(0, 1);
      prog_data  = 8'($urandom);
      prog_last  = ($urandom_range(0, 7) == 0);
      check_outs("rnd");
      tick();
    end
    prog_mode = 0;
    idle_inputs();
    tick();
    tick();
    check_outs("rnd_end");
    for (int i = 0; i < 16; i++) read_addr("rnd_rb", 4'(i), m_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ram_mar_unit

// File: doc/ram_mar_unit.md
Name: ram_mar_unit

Overview:
- Memory-side responder to the control block's memory control signals: memory address register (MAR) plus a DEPTH x DATA_W flop-based RAM on the shared 8-bit CPU bus.
- Loads MAR from the bus, drives RAM data onto the bus, and writes bus data into RAM when the control signals say so.
- Includes a byte-wide program loader with a valid/ready handshake, used to fill RAM from the chip pins while the CPU is held off the memory.

Parameters:
ADDR_W, 4, MAR and RAM address width
DATA_W, 8, RAM word and bus width
DEPTH, 16, number of RAM words; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
bus_in  input  DATA_W  current value of the shared CPU bus
bus_out  output  DATA_W  RAM data driven toward the bus
bus_oe  output  1  high when bus_out must be placed on the bus
lm  input  1  load MAR from bus_in[ADDR_W-1:0], active high
ce  input  1  RAM output enable to bus, active high
we  input  1  RAM write from bus_in at MAR, active high
prog_mode  input  1  request loader ownership of RAM
prog_valid  input  1  prog_data holds a valid byte
prog_data  input  DATA_W  byte to store
prog_last  input  1  qualifies the final byte of a program
prog_ready  output  1  loader accepts a byte this cycle
prog_done  output  1  load complete
mar  output  ADDR_W  current MAR value, for debug

Behaviour:
- Clock and reset: one clock `clk`; `rst_n` is an asynchronous, active-low reset.
- Reset values:
  - mar = 0 and all RAM words = 0.
  - Loader in IDLE with ptr = 0.
  - prog_ready = 0, prog_done = 0, bus_oe = 0, bus_out = 0.
- CPU path (active only when the loader is in IDLE):
  - lm = 1: mar <= bus_in[ADDR_W-1:0] at the next edge.
  - we = 1 and ce = 0: mem[mar] <= bus_in at the next edge.
  - lm and we in the same cycle: the write uses the old mar, and mar updates in the same edge.
  - ce = 1: combinational read. bus_oe = 1 and bus_out = mem[mar] with zero latency.
  - When ce = 0: bus_out = 0.
  - ce and we both high (bus contention): the write is suppressed and the read proceeds. No state changes except lm.
  - RAM read after a write to the same address in the previous cycle returns the new data.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE:
    - prog_ready = 0, prog_done = 0.
    - prog_mode = 1 -> LOAD at the next edge, ptr <= 0.
  - LOAD:
    - prog_ready = 1 (registered state decode).
    - prog_valid = 1 (handshake): mem[ptr] <= prog_data, ptr <= ptr + 1.
    - If ptr == DEPTH-1 or prog_last = 1 on an accepted byte -> DONE.
    - prog_mode = 0 (abort) -> IDLE. An abort in the same cycle as a handshake still writes the byte. Bytes already written are kept.
  - DONE:
    - prog_done = 1, prog_ready = 0.
    - Stays in DONE while prog_mode = 1; prog_mode = 0 -> IDLE.
- While the loader is not in IDLE:
  - lm, ce and we are ignored.
  - bus_oe = 0.
  - mar holds its value.
- ptr does not wrap: DONE is entered on the DEPTH-th byte, so no write past DEPTH-1.
- prog_valid while not in LOAD is ignored, with no write.
- Reset asserted mid-load: immediately IDLE, RAM cleared, outputs at reset values.

Decomposition:
- Shared CPU package holds:
  - the ADDR_W/DATA_W defaults;
  - the loader state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2);
  - the control-word bit indices for lm/ce/we, so the top level slices control_signals consistently.
- One sub-module is natural: prog_loader (the FSM plus ptr, emitting a write enable, address and data). It is muxed with the CPU write port inside ram_mar_unit.

Test Plan:
- Reset then read:
  - Stimulus: reset, then lm=1 with bus_in=8'h05; next cycle ce=1.
  - Required: mar=5, bus_oe=1, bus_out=8'h00.
- CPU write and readback:
  - Stimulus: lm with bus_in=8'h03; then we=1 with bus_in=8'hA5; then ce=1.
  - Required: bus_out=8'hA5. Concurrent lm+we with bus_in=8'h07 writes 8'h07 to the old mar=3 and sets mar=7.
- Full program load:
  - Stimulus: prog_mode=1; stream 16 bytes 8'h10..8'h1F with prog_valid held high.
  - Required: prog_ready high for exactly 16 cycles, then prog_done=1; readback of addr i gives 8'h10+i.
  - During the load, ce=1 gives bus_oe=0.
- Early termination:
  - Stimulus: send 3 bytes, the third with prog_last=1.
  - Required: DONE after byte 3; addresses 3..15 unchanged.
  - prog_mode=0 returns to IDLE; CPU access works again.
- Abort and reset mid-load:
  - Stimulus: drop prog_mode after 2 bytes.
  - Required: IDLE, both bytes kept.
  - Restart the load, then assert rst_n=0 mid-stream: RAM all zero, prog_ready=0 asynchronously.
- Contention:
  - Stimulus: ce=1 and we=1 with bus_in=8'hFF at mar=2 holding 8'h3C.
  - Required: bus_out=8'h3C; mem[2] still 8'h3C afterwards.
